// File: rtl/crc_stream_param.sv
// Parametrised streaming CRC generator/checker: valid/ready word input, one DW-bit word per clock,
// finished CRC presented on a valid/ready output. Define CRC_CHECK_EN to add the crc_match output.
module crc_stream_param #(
    parameter int          CW      = 32,
    parameter int          DW      = 32,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter bit          REFIN   = 1'b1,
    parameter bit          REFOUT  = 1'b1,
    parameter logic [31:0] RESIDUE = 32'h2144DF1C
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_eof,
    output logic          in_ready,
    output logic [CW-1:0] crc_out,
    output logic          crc_valid,
    input  logic          crc_ready,
    output logic [15:0]   frame_cnt
`ifdef CRC_CHECK_EN
    ,
    output logic          crc_match
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    localparam logic [CW-1:0] POLY_W   = POLY[CW-1:0];
    localparam logic [CW-1:0] INIT_W   = INIT[CW-1:0];
    localparam logic [CW-1:0] XOROUT_W = XOROUT[CW-1:0];

    // Bit-serial shift-left LFSR unrolled over the whole word; byte 0 is in_data[7:0] when
    // REFIN=1 (each byte LSB first), otherwise the top byte, MSB first.
    function automatic logic [CW-1:0] crc_update(input logic [CW-1:0] crc_in,
                                                 input logic [DW-1:0] data);
        logic [CW-1:0] r;
        logic          din;
        logic          fb;
        r = crc_in;
        for (int b = 0; b < DW / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                din = REFIN ? data[8 * b + i] : data[DW - 1 - 8 * b - i];
                fb  = r[CW-1] ^ din;
                r   = {r[CW-2:0], 1'b0} ^ (fb ? POLY_W : '0);
            end
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] bit_reverse(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < CW; i++) begin
            r[i] = v[CW - 1 - i];
        end
        return r;
    endfunction

    state_e        state_q,     state_d;
    logic [CW-1:0] crc_reg_q,   crc_reg_d;
    logic [CW-1:0] crc_out_q,   crc_out_d;
    logic          crc_valid_q, crc_valid_d;
    logic          in_ready_q,  in_ready_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
`ifdef CRC_CHECK_EN
    localparam logic [CW-1:0] RESIDUE_W = RESIDUE[CW-1:0];
    logic          crc_match_q, crc_match_d;
`endif

    logic          accept;
    logic [CW-1:0] crc_seed;
    logic [CW-1:0] crc_next;
    logic [CW-1:0] crc_final;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        crc_reg_d   = crc_reg_q;
        crc_out_d   = crc_out_q;
        crc_valid_d = crc_valid_q;
        frame_cnt_d = frame_cnt_q;
`ifdef CRC_CHECK_EN
        crc_match_d = crc_match_q;
`endif

        accept    = in_valid & in_ready_q;
        crc_seed  = in_sof ? INIT_W : crc_reg_q;
        crc_next  = crc_update(crc_seed, in_data);
        crc_final = (REFOUT ? bit_reverse(crc_next) : crc_next) ^ XOROUT_W;

        case (state_q)
            S_IDLE: begin
                if (accept && in_sof) begin
                    crc_reg_d = crc_next;
                    state_d   = in_eof ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                // A sof here restarts the frame: crc_seed already selects INIT.
                if (accept) begin
                    crc_reg_d = crc_next;
                    if (in_eof) begin
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (crc_ready) begin
                    state_d     = S_IDLE;
                    crc_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result is captured on the same edge that accepts the eof word.
        if (state_q != S_OUT && state_d == S_OUT) begin
            crc_out_d   = crc_final;
            crc_valid_d = 1'b1;
`ifdef CRC_CHECK_EN
            crc_match_d = (crc_final == RESIDUE_W);
`endif
        end

        in_ready_d = (state_d != S_OUT);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            crc_reg_q   <= INIT_W;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            frame_cnt_q <= 16'd0;
`ifdef CRC_CHECK_EN
            crc_match_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            crc_reg_q   <= crc_reg_d;
            crc_out_q   <= crc_out_d;
            crc_valid_q <= crc_valid_d;
            in_ready_q  <= in_ready_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CRC_CHECK_EN
            crc_match_q <= crc_match_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign crc_out   = crc_out_q;
    assign crc_valid = crc_valid_q;
    assign frame_cnt = frame_cnt_q;
`ifdef CRC_CHECK_EN
    assign crc_match = crc_match_q;
`else
    // Check mode compiled out: no residue comparator exists in this build.
`endif

endmodule

// File: tb/tb_crc_stream_param.sv
// Scoreboard bench for crc_stream_param: three configurations (CRC-32/8-bit, CRC-16/8-bit,
// CRC-32/32-bit); stimulus pushes expected CRCs, per-DUT monitors pop on each output handshake.
module tb_crc_stream_param;

    typedef struct {
        logic [31:0] crc;
        logic        match;
    } exp_t;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    // DUT a: CRC-32, DW=8
    logic [7:0]  a_data;
    logic        a_valid, a_sof, a_eof, a_in_ready;
    logic [31:0] a_crc_out;
    logic        a_crc_valid, a_crc_ready;
    logic [15:0] a_frame_cnt;
`ifdef CRC_CHECK_EN
    logic        a_crc_match;
`endif
    exp_t        a_q[$];
    exp_t        a_exp;

    // DUT b: CRC-16/CCITT-FALSE, DW=8
    logic [7:0]  b_data;
    logic        b_valid, b_sof, b_eof, b_in_ready;
    logic [15:0] b_crc_out;
    logic        b_crc_valid, b_crc_ready;
    logic [15:0] b_frame_cnt;
`ifdef CRC_CHECK_EN
    logic        b_crc_match;
`endif
    logic [15:0] b_q[$];
    logic [15:0] b_exp;

    // DUT c: CRC-32, DW=32
    logic [31:0] c_data;
    logic        c_valid, c_sof, c_eof, c_in_ready;
    logic [31:0] c_crc_out;
    logic        c_crc_valid, c_crc_ready;
    logic [15:0] c_frame_cnt;
`ifdef CRC_CHECK_EN
    logic        c_crc_match;
`endif
    logic [31:0] c_q[$];
    logic [31:0] c_exp;

    crc_stream_param #(.CW(32), .DW(8)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_sof(a_sof),
        .in_eof(a_eof), .in_ready(a_in_ready), .crc_out(a_crc_out), .crc_valid(a_crc_valid),
        .crc_ready(a_crc_ready), .frame_cnt(a_frame_cnt)
`ifdef CRC_CHECK_EN
        , .crc_match(a_crc_match)
`endif
    );

    crc_stream_param #(
        .CW(16), .DW(8), .POLY(32'h00001021), .INIT(32'h0000FFFF), .XOROUT(32'h0),
        .REFIN(1'b0), .REFOUT(1'b0), .RESIDUE(32'h0)
    ) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_sof(b_sof),
        .in_eof(b_eof), .in_ready(b_in_ready), .crc_out(b_crc_out), .crc_valid(b_crc_valid),
        .crc_ready(b_crc_ready), .frame_cnt(b_frame_cnt)
`ifdef CRC_CHECK_EN
        , .crc_match(b_crc_match)
`endif
    );

    crc_stream_param #(.CW(32), .DW(32)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_sof(c_sof),
        .in_eof(c_eof), .in_ready(c_in_ready), .crc_out(c_crc_out), .crc_valid(c_crc_valid),
        .crc_ready(c_crc_ready), .frame_cnt(c_frame_cnt)
`ifdef CRC_CHECK_EN
        , .crc_match(c_crc_match)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_sof = 1'b0; a_eof = 1'b0; a_data = 'x;
        b_valid = 1'b0; b_sof = 1'b0; b_eof = 1'b0; b_data = 'x;
        c_valid = 1'b0; c_sof = 1'b0; c_eof = 1'b0; c_data = 'x;
    endtask

    // One byte word on DUT a (sel=0) or b (sel=1); returns 1 time unit after the accepting edge.
    task automatic word8(input int sel, input logic [7:0] d, input logic sof, input logic eof);
        if (sel == 0) begin
            a_data = d; a_sof = sof; a_eof = eof; a_valid = 1'b1;
        end else begin
            b_data = d; b_sof = sof; b_eof = eof; b_valid = 1'b1;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic frame8(input int sel, input string s, input bit with_eof);
        for (int i = 0; i < s.len(); i++) begin
            word8(sel, s[i], (i == 0), with_eof && (i == s.len() - 1));
        end
    endtask

    task automatic word32(input logic [31:0] d, input logic sof, input logic eof);
        c_data = d; c_sof = sof; c_eof = eof; c_valid = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_crc_valid"}, a_crc_valid, 0);
        check({tag, "_crc_out"},   a_crc_out, 0);
        check({tag, "_frame_cnt"}, a_frame_cnt, 0);
        check({tag, "_in_ready"},  a_in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (a_crc_valid && a_crc_ready) begin
            check("a_pending", a_q.size() != 0, 1);
            if (a_q.size() != 0) begin
                a_exp = a_q.pop_front();
                check("a_crc_out", a_crc_out, a_exp.crc);
`ifdef CRC_CHECK_EN
                check("a_crc_match", a_crc_match, a_exp.match);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (b_crc_valid && b_crc_ready) begin
            check("b_pending", b_q.size() != 0, 1);
            if (b_q.size() != 0) begin
                b_exp = b_q.pop_front();
                check("b_crc_out", b_crc_out, b_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (c_crc_valid && c_crc_ready) begin
            check("c_pending", c_q.size() != 0, 1);
            if (c_q.size() != 0) begin
                c_exp = c_q.pop_front();
                check("c_crc_out", c_crc_out, c_exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        a_crc_ready = 1'b1;
        b_crc_ready = 1'b1;
        c_crc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_a_reset("rst0");
        check("rst0_b_in_ready", b_in_ready, 1);
        check("rst0_c_crc_valid", c_crc_valid, 0);

        // CRC-16/CCITT-FALSE over "123456789"
        b_q.push_back(16'h29B1);
        frame8(1, "123456789", 1'b1);
        @(posedge clk); #1;
        check("b_frame_cnt", b_frame_cnt, 1);

        // Single all-zero 32-bit word with sof&eof, twice
        for (int k = 0; k < 2; k++) begin
            c_q.push_back(32'h2144DF1C);
            word32(32'h0, 1'b1, 1'b1);
            check("c_valid_latency", c_crc_valid, 1);
            check("c_in_ready_out", c_in_ready, 0);
            @(posedge clk); #1;
        end
        check("c_frame_cnt", c_frame_cnt, 2);

        // CRC-32 over "123456789", immediate handshake
        a_q.push_back('{32'hCBF43926, 1'b0});
        frame8(0, "123456789", 1'b1);
        check("t1_crc_valid", a_crc_valid, 1);
        check("t1_in_ready", a_in_ready, 0);
        @(posedge clk); #1;
        check("t1_valid_one_cycle", a_crc_valid, 0);
        check("t1_in_ready_back", a_in_ready, 1);
        check("t1_frame_cnt", a_frame_cnt, 1);

        // Output back-pressure: hold crc_ready low with a word presented
        a_crc_ready = 1'b0;
        a_q.push_back('{32'hCBF43926, 1'b0});
        frame8(0, "123456789", 1'b1);
        for (int k = 0; k < 5; k++) begin
            a_data = 8'h31; a_sof = 1'b1; a_eof = 1'b1; a_valid = 1'b1;
            check("t4_crc_valid_held", a_crc_valid, 1);
            check("t4_crc_out_held", a_crc_out, 32'hCBF43926);
            check("t4_in_ready_low", a_in_ready, 0);
            @(posedge clk); #1;
        end
        idle_inputs();
        a_crc_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_crc_valid_cleared", a_crc_valid, 0);
        check("t4_in_ready_back", a_in_ready, 1);
        check("t4_frame_cnt", a_frame_cnt, 2);

        // Non-sof word with eof in IDLE must be dropped (no output)
        word8(0, 8'h41, 1'b0, 1'b1);
        check("drop_no_valid", a_crc_valid, 0);

        // Restart: "12" then sof on "123456789"
        frame8(0, "12", 1'b0);
        a_q.push_back('{32'hCBF43926, 1'b0});
        frame8(0, "123456789", 1'b1);
        check("t5_cnt_before", a_frame_cnt, 2);
        @(posedge clk); #1;
        check("t5_cnt_after", a_frame_cnt, 3);

`ifdef CRC_CHECK_EN
        // Frame carrying its own CRC gives the residue
        a_q.push_back('{32'h2144DF1C, 1'b1});
        frame8(0, "123456789", 1'b0);
        word8(0, 8'h26, 1'b0, 1'b0);
        word8(0, 8'h39, 1'b0, 1'b0);
        word8(0, 8'hF4, 1'b0, 1'b0);
        word8(0, 8'hCB, 1'b0, 1'b1);
        @(posedge clk); #1;
`endif

        // Reset mid-frame, then an eof-only word must not produce a result
        frame8(0, "1234", 1'b0);
        pulse_reset();
        check_a_reset("t6a");
        word8(0, 8'h35, 1'b0, 1'b1);
        check("t6a_dropped", a_crc_valid, 0);

        // Reset while in OUT
        a_crc_ready = 1'b0;
        frame8(0, "123456789", 1'b1);
        check("t6b_in_out", a_crc_valid, 1);
        pulse_reset();
        check_a_reset("t6b");
        a_crc_ready = 1'b1;

        // Clean frame after reset
        a_q.push_back('{32'hCBF43926, 1'b0});
        frame8(0, "123456789", 1'b1);
        @(posedge clk); #1;
        check("t6_clean_cnt", a_frame_cnt, 1);

        for (int i = 0; i < 20 && (a_q.size() + b_q.size() + c_q.size()) != 0; i++) begin
            @(posedge clk);
        end
        check("queues_drained", a_q.size() + b_q.size() + c_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
